// File: rtl/fft_pkg.sv
// Shared FFT stream definitions: complex word layout and packing helper.
// The output-side controller uses this package too.
package fft_pkg;

  localparam int unsigned FFT_DATA_W        = 32;
  localparam int unsigned CPLX_RE_LSB       = 0;
  localparam int unsigned CPLX_IM_LSB       = 16;
  localparam int unsigned FRAME_LEN_DEFAULT = 1024;

  typedef enum logic [0:0] {StIdle, StRun} in_state_e;

  function automatic logic [FFT_DATA_W-1:0] pack_cplx(input logic [15:0] re,
                                                      input logic [15:0] im);
    logic [FFT_DATA_W-1:0] w;
    w = '0;
    w[CPLX_RE_LSB +: 16] = re;
    w[CPLX_IM_LSB +: 16] = im;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered output word. The output register counts toward DEPTH,
// so at most DEPTH entries are held in total.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    mem_cnt_q, total;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             do_pop, do_push, load;

  always_comb begin
    do_pop  = pop & dout_valid_q;
    total   = mem_cnt_q + CW'(dout_valid_q);
    full    = (total == CW'(DEPTH));
    empty   = (total == '0);
    // A full FIFO still takes a word when the output register drains in the same cycle.
    do_push = push & (~full | do_pop);
    load    = (mem_cnt_q != '0) & (~dout_valid_q | do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (load) begin
        dout_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_pop | load) begin
        dout_valid_q <= load;
      end
      mem_cnt_q <= mem_cnt_q + CW'(do_push) - CW'(load);
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: rtl/fft_input_framer.sv
// FFT input framer: buffers strobed real samples, packs them as complex words and frames the
// valid/ready output stream into FRAME_LEN-word frames. Dropped samples set a sticky flag.
module fft_input_framer
  import fft_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FRAME_LEN  = FRAME_LEN_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_sample_valid,
  input  logic [SAMPLE_W-1:0]   i_sample,
  output logic                  o_data_valid,
  output logic [FFT_DATA_W-1:0] o_data,
  output logic                  o_data_last,
  input  logic                  i_data_ready,
  output logic                  o_overflow,
  input  logic                  i_clear_overflow,
  output logic [15:0]           o_frame_count
);

  localparam int unsigned IW = $clog2(FRAME_LEN);

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  in_state_e     state_q, state_d;
  logic [IW-1:0] in_idx_q, out_idx_q;
  logic          ovf_q;
  logic [15:0]   frame_cnt_q;
  logic          boundary, take, accept, drop, pop_now, fifo_full, fifo_empty;
  logic [15:0]   sample_re;

  // Reset asserts asynchronously but releases on the clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    state_d   = state_q;
    boundary  = (in_idx_q == '0);
    unique case (state_q)
      StIdle:  if (i_enable & boundary) state_d = StRun;
      StRun:   if (!i_enable & boundary) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    pop_now   = o_data_valid & i_data_ready;
    // At a frame boundary with enable low the framer is leaving RUN and takes nothing.
    take      = (state_q == StRun) & i_sample_valid & ~(boundary & ~i_enable);
    accept    = take & (~fifo_full | pop_now);
    drop      = take & fifo_full & ~pop_now;
    sample_re = 16'($signed(i_sample));
  end

  sync_fifo #(
    .WIDTH (FFT_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (i_clk),
    .rst_n      (rst_n),
    .push       (accept),
    .din        (pack_cplx(sample_re, 16'h0000)),
    .pop        (i_data_ready),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .dout       (o_data),
    .dout_valid (o_data_valid)
  );

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      in_idx_q <= in_idx_q + IW'(accept);
      if (pop_now) begin
        out_idx_q <= out_idx_q + IW'(1);
        if (o_data_last) begin
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (i_clear_overflow) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign o_data_last   = o_data_valid & (out_idx_q == IW'(FRAME_LEN - 1));
  assign o_overflow    = ovf_q;
  assign o_frame_count = frame_cnt_q;

  assert property (@(posedge i_clk) disable iff (!rst_n) fifo_empty |-> !o_data_valid);

endmodule

// File: tb/tb_fft_input_framer.sv
// Scoreboard bench for fft_input_framer: a queue-based reference model predicts acceptance,
// drops, output timing and frame counts; a negedge monitor compares the DUT against it.
module tb_fft_input_framer;

  localparam int SW    = 12;
  localparam int FL    = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [SW-1:0] sample = '0;
  logic        data_valid;
  logic [31:0] data;
  logic        data_last;
  logic        data_ready = 1'b0;
  logic        overflow;
  logic        clear_overflow = 1'b0;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   stamp_q[$];
  int   edge_n = 0;
  bit   m_run = 0;
  int   m_in_idx = 0;
  int   m_out_cnt = 0;
  bit   m_valid = 0;
  bit   m_ovf = 0;
  int   m_fc = 0;

  fft_input_framer #(
    .SAMPLE_W   (SW),
    .FRAME_LEN  (FL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_enable         (enable),
    .i_sample_valid   (sample_valid),
    .i_sample         (sample),
    .o_data_valid     (data_valid),
    .o_data           (data),
    .o_data_last      (data_last),
    .i_data_ready     (data_ready),
    .o_overflow       (overflow),
    .i_clear_overflow (clear_overflow),
    .o_frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mpack(input logic [SW-1:0] s);
    int v;
    v = int'(s);
    if (v >= (1 << (SW - 1))) v = v - (1 << SW);
    return {16'h0000, 16'(v)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: a sample enters the queue on acceptance, becomes visible one edge later,
  // and leaves on a handshake. Occupancy is simply the queue length.
  initial begin : model
    bit pop, full, boundary, take;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        stamp_q.delete();
        m_run = 0; m_in_idx = 0; m_out_cnt = 0; m_valid = 0; m_ovf = 0; m_fc = 0;
      end else begin
        edge_n++;
        pop      = m_valid && data_ready;
        full     = (stamp_q.size() == DEPTH);
        boundary = (m_in_idx == 0);
        take     = m_run && sample_valid && !(boundary && !enable);
        if (pop) begin
          void'(stamp_q.pop_front());
          m_out_cnt++;
          if (m_out_cnt == FL) begin
            m_out_cnt = 0;
            m_fc = (m_fc + 1) % 65536;
          end
        end
        if (take && (!full || pop)) begin
          stamp_q.push_back(edge_n);
          exp_q.push_back('{d: mpack(sample), l: (m_in_idx == FL - 1)});
          m_in_idx = (m_in_idx + 1) % FL;
        end
        if (take && full && !pop) m_ovf = 1;
        else if (clear_overflow) m_ovf = 0;
        if (!m_run && enable && boundary) m_run = 1;
        else if (m_run && !enable && boundary) m_run = 0;
        m_valid = (stamp_q.size() > 0) && (stamp_q[0] < edge_n);
      end
    end
  end

  initial begin : monitor
    bit          stall_prev;
    logic [31:0] stall_data;
    exp_t        e;
    stall_prev = 0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_count", frame_count, 0);
        stall_prev = 0;
      end else begin
        chk("valid", data_valid, m_valid);
        chk("overflow", overflow, m_ovf);
        chk("frame_count", frame_count, m_fc);
        if (stall_prev && data_valid) chk("stall_hold", data, stall_data);
        if (data_valid && data_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", data, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            chk("data", data, e.d);
            chk("last", data_last, e.l);
          end
        end
        stall_prev = data_valid && !data_ready;
        stall_data = data;
      end
    end
  end

  task automatic step(input bit en, input bit sv, input logic [SW-1:0] s, input bit rdy,
                      input bit clr);
    enable = en; sample_valid = sv; sample = s; data_ready = rdy; clear_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, '0, rdy, 0);
  endtask

  initial begin : stim
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3, 1);

    // Basic frame of 1..8 with ready high.
    step(1, 0, '0, 1, 0);
    for (int i = 1; i <= FL; i++) step(1, 1, SW'(i), 1, 0);
    idle(4, 1);
    chk("t1_frames", frame_count, 1);

    // Sign extension of a 12-bit sample.
    step(1, 1, 12'hF80, 1, 0);
    step(1, 1, 12'h07F, 1, 0);
    for (int i = 0; i < FL - 2; i++) step(1, 1, SW'($urandom), 1, 0);

    // Stall: 20 strobes into a 16-deep FIFO.
    for (int i = 1; i <= 20; i++) step(1, 1, SW'(i), 0, 0);
    chk("t3_overflow", overflow, 1);
    step(1, 1, SW'(21), 0, 1);
    chk("ovf_set_wins", overflow, 1);
    step(1, 0, '0, 0, 1);
    chk("ovf_cleared", overflow, 0);
    // Full FIFO with a simultaneous pop takes the sample.
    step(1, 1, SW'(100), 1, 0);
    chk("t4_no_overflow", overflow, 0);
    for (int i = 0; i < FL - 1; i++) step(1, 1, SW'(200 + i), 1, 0);
    step(0, 0, '0, 1, 0);
    idle(20, 1);

    // Enable drops after 3 samples: frame still completes, later strobes ignored.
    step(1, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, SW'(300 + i), 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, SW'(310 + i), 1, 0);
    idle(4, 1);
    chk("t5_no_overflow", overflow, 0);

    // Reset mid-frame after the fifth word has gone out.
    step(1, 0, '0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 1, SW'(400 + i), 1, 0);
    step(1, 0, '0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", data_valid, 0);
    chk("async_rst_data", data, 0);
    chk("async_rst_last", data_last, 0);
    chk("async_rst_frames", frame_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3, 1);
    step(1, 0, '0, 1, 0);
    for (int i = 0; i < FL; i++) step(1, 1, SW'(500 + i), 1, 0);
    idle(4, 1);
    chk("t6_frames", frame_count, 1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 8) != 0, ($urandom % 4) != 0, SW'($urandom), ($urandom % 3) != 0,
           ($urandom % 16) == 0);
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(0, 0, '0, 1, 0);
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
